multicycle_controller: RTL and testbench

//  Multi-cycle RV32I control FSM. Sequences fetch, decode, execute, memory and writeback; drives the
//  IR/PC/regfile strobes, the immediate-register enable (latches sextimm) and the ALU operand muxes.

---
 rtl/riscv_ctrl_defs.sv | 48 ++++
 rtl/multicycle_controller_opcode_classifier.sv | 28 ++
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_defs.sv
// Shared control encodings for the multi-cycle RV32I core: opcodes, FSM states,
// instruction classes and the operand / writeback mux selects used by the datapath.
package riscv_ctrl_defs;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      OP_R      = 4'd0,
      OP_I      = 4'd1,
      OP_LOAD   = 4'd2,
      OP_STORE  = 4'd3,
      OP_BRANCH = 4'd4,
      OP_JAL    = 4'd5,
      OP_JALR   = 4'd6,
      OP_LUI    = 4'd7,
      OP_AUIPC  = 4'd8
   } op_class_t;

   localparam logic [1:0] SRC_A_RS1  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic [1:0] WB_ALU     = 2'd0;
   localparam logic [1:0] WB_MEM     = 2'd1;
   localparam logic [1:0] WB_PC4     = 2'd2;

endpackage

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational RV32I opcode classifier: maps opcode[6:0] to an instruction class
// and flags anything outside the supported base set as illegal.
module opcode_classifier
   import riscv_ctrl_defs::*;
(
   input  logic [6:0] opcode,
   output op_class_t  op_class,
   output logic       illegal
);

   always_comb begin
      op_class = OP_R;
      illegal  = 1'b0;
      case (opcode)
         OPC_R:      op_class = OP_R;
         OPC_I:      op_class = OP_I;
         OPC_LOAD:   op_class = OP_LOAD;
         OPC_STORE:  op_class = OP_STORE;
         OPC_BRANCH: op_class = OP_BRANCH;
         OPC_JAL:    op_class = OP_JAL;
         OPC_JALR:   op_class = OP_JALR;
         OPC_LUI:    op_class = OP_LUI;
         OPC_AUIPC:  op_class = OP_AUIPC;
         default:    illegal  = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing with a
// req/ack memory handshake, ack timeout and a sticky fault state.
module multicycle_controller
   import riscv_ctrl_defs::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] instruction,
   input  logic                  mem_ack,
   input  logic                  branch_taken,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  mem_sel_data,
   output logic                  ir_write,
   output logic                  imm_en,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic                  pc_write,
   output logic                  pc_src,
   output logic                  reg_write,
   output logic [1:0]            wb_sel,
   output logic                  fault,
   output logic [2:0]            state
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_d;
   op_class_t        op_class_q, op_class_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   op_class_t        dec_class;
   logic             dec_illegal;
   logic             waiting;
   logic             timeout;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^instruction[DATA_WIDTH-1:7];

   opcode_classifier u_classifier (
      .opcode   (instruction[6:0]),
      .op_class (dec_class),
      .illegal  (dec_illegal)
   );

   assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
   assign timeout = waiting && !mem_ack && (wait_cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_FETCH;
         op_class_q <= OP_R;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         op_class_q <= op_class_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_class_d = op_class_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ack)      state_d = ST_DECODE;
            else if (timeout) state_d = ST_FAULT;
         end
         ST_DECODE: begin
            op_class_d = dec_class;
            state_d    = dec_illegal ? ST_FAULT : ST_EXEC;
         end
         ST_EXEC: begin
            if (op_class_q == OP_BRANCH)
               state_d = ST_FETCH;
            else if ((op_class_q == OP_LOAD) || (op_class_q == OP_STORE))
               state_d = ST_MEM;
            else
               state_d = ST_WB;
         end
         ST_MEM: begin
            if (mem_ack)      state_d = (op_class_q == OP_STORE) ? ST_FETCH : ST_WB;
            else if (timeout) state_d = ST_FAULT;
         end
         ST_WB:    state_d = ST_FETCH;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_FAULT;
      endcase

      // Counter only runs while a request sits un-acked in the same state.
      if (mem_ack || (state_d != state_q) || !waiting)
         wait_cnt_d = '0;
      else
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_write     = 1'b0;
      imm_en       = 1'b0;
      alu_src_a    = SRC_A_RS1;
      alu_src_b    = SRC_B_RS2;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = WB_ALU;
      fault        = 1'b0;
      state        = state_q;
      case (state_q)
         ST_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ack;
         end
         ST_DECODE: imm_en = 1'b1;
         ST_EXEC: begin
            case (op_class_q)
               OP_I, OP_LOAD, OP_STORE, OP_JALR: alu_src_b = SRC_B_IMM;
               OP_LUI: begin
                  alu_src_a = SRC_A_ZERO;
                  alu_src_b = SRC_B_IMM;
               end
               OP_AUIPC, OP_JAL: begin
                  alu_src_a = SRC_A_PC;
                  alu_src_b = SRC_B_IMM;
               end
               OP_BRANCH: begin
                  pc_write = 1'b1;
                  pc_src   = branch_taken;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_sel_data = 1'b1;
            mem_we       = (op_class_q == OP_STORE);
            pc_write     = mem_ack && (op_class_q == OP_STORE);
         end
         ST_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            if (op_class_q == OP_LOAD) begin
               wb_sel = WB_MEM;
            end else if ((op_class_q == OP_JAL) || (op_class_q == OP_JALR)) begin
               wb_sel = WB_PC4;
               pc_src = 1'b1;
            end
         end
         ST_FAULT: fault = 1'b1;
         default:  fault = 1'b1;
      endcase

      if (!rstn) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_sel_data = 1'b0;
         ir_write     = 1'b0;
         imm_en       = 1'b0;
         alu_src_a    = 2'd0;
         alu_src_b    = 2'd0;
         pc_write     = 1'b0;
         pc_src       = 1'b0;
         reg_write    = 1'b0;
         wb_sel       = 2'd0;
         fault        = 1'b0;
         state        = 3'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller: one vector per clock cycle,
// plus hand-written loops for the sticky fault, ack timeout and mid-transaction reset.
module tb_multicycle_controller;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_JAL   = 32'h0080006F;
   localparam logic [31:0] I_JALR  = 32'h00008067;
   localparam logic [31:0] I_LUI   = 32'h123452B7;
   localparam logic [31:0] I_AUIPC = 32'h00001297;
   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_BAD   = 32'h0000007F;

   typedef struct packed {
      logic [2:0] st;
      logic       req;
      logic       we;
      logic       sel;
      logic       irw;
      logic       imm;
      logic [1:0] a;
      logic [1:0] b;
      logic       pcw;
      logic       pcs;
      logic       rw;
      logic [1:0] wb;
      logic       flt;
   } out_t;

   typedef struct {
      logic        rstn;
      logic [31:0] instr;
      logic        ack;
      logic        bt;
      out_t        exp;
   } vec_t;

   logic        clk;
   logic        rstn;
   logic [31:0] instruction;
   logic        mem_ack;
   logic        branch_taken;
   logic        mem_req, mem_we, mem_sel_data, ir_write, imm_en;
   logic [1:0]  alu_src_a, alu_src_b, wb_sel;
   logic        pc_write, pc_src, reg_write, fault;
   logic [2:0]  state;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   out_t act;

   multicycle_controller #(.DATA_WIDTH(32), .ACK_TIMEOUT(15)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .instruction  (instruction),
      .mem_ack      (mem_ack),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_sel_data (mem_sel_data),
      .ir_write     (ir_write),
      .imm_en       (imm_en),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .fault        (fault),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign act = {state, mem_req, mem_we, mem_sel_data, ir_write, imm_en,
                 alu_src_a, alu_src_b, pc_write, pc_src, reg_write, wb_sel, fault};

   function automatic out_t o(input logic [2:0] st, input logic req, input logic we,
                              input logic sel, input logic irw, input logic imm,
                              input logic [1:0] a, input logic [1:0] b, input logic pcw,
                              input logic pcs, input logic rw, input logic [1:0] wb,
                              input logic flt);
      return {st, req, we, sel, irw, imm, a, b, pcw, pcs, rw, wb, flt};
   endfunction

   task automatic addVec(input logic r, input logic [31:0] i, input logic k,
                         input logic bt, input out_t e);
      vec_t v;
      v.rstn  = r;
      v.instr = i;
      v.ack   = k;
      v.bt    = bt;
      v.exp   = e;
      vecs.push_back(v);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
   task automatic applyStimulus(input logic r, input logic [31:0] i, input logic k, input logic bt);
      @(negedge clk);
      rstn         = r;
      instruction  = i;
      mem_ack      = k;
      branch_taken = bt;
      #1;
   endtask

   task automatic checkOutput(input out_t e, input string tag);
      checks++;
      if (act !== e) begin
         errors++;
         $display("[TB] FAIL %s: got %05h expected %05h (state got %0d exp %0d)",
                  tag, act, e, act.st, e.st);
      end
   endtask

   initial begin
      out_t zero, fetch_wait, fetch_ack, decode, fault_o;
      zero       = o(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0);
      fetch_wait = o(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0);
      fetch_ack  = o(3'd0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0);
      decode     = o(3'd1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0);
      fault_o    = o(3'd7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 1);

      rstn = 1'b0; instruction = '0; mem_ack = 1'b0; branch_taken = 1'b0;
      repeat (2) @(posedge clk);

      // Reset with ack high: ir_write must still be forced low.
      addVec(0, I_ADDI, 1, 0, zero);
      // ADDI: F,D,E,W
      addVec(1, I_ADDI, 1, 0, fetch_ack);
      addVec(1, I_ADDI, 0, 0, decode);
      addVec(1, I_ADDI, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_ADDI, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 2'd0, 0));
      // LW: data ack delayed 3 cycles
      addVec(1, I_LW, 1, 0, fetch_ack);
      addVec(1, I_LW, 0, 0, decode);
      addVec(1, I_LW, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_LW, 0, 0, o(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0));
      addVec(1, I_LW, 0, 0, o(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0));
      addVec(1, I_LW, 0, 0, o(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0));
      addVec(1, I_LW, 1, 0, o(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0));
      addVec(1, I_LW, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 2'd1, 0));
      // BEQ taken; IR changed to ADDI in EXEC must be ignored
      addVec(1, I_BEQ, 1, 0, fetch_ack);
      addVec(1, I_BEQ, 0, 0, decode);
      addVec(1, I_ADDI, 0, 1, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0, 2'd0, 0));
      // BEQ not taken
      addVec(1, I_BEQ, 1, 0, fetch_ack);
      addVec(1, I_BEQ, 0, 0, decode);
      addVec(1, I_BEQ, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 2'd0, 0));
      // JAL
      addVec(1, I_JAL, 1, 0, fetch_ack);
      addVec(1, I_JAL, 0, 0, decode);
      addVec(1, I_JAL, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_JAL, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 1, 2'd2, 0));
      // JALR
      addVec(1, I_JALR, 1, 0, fetch_ack);
      addVec(1, I_JALR, 0, 0, decode);
      addVec(1, I_JALR, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_JALR, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 1, 2'd2, 0));
      // LUI
      addVec(1, I_LUI, 1, 0, fetch_ack);
      addVec(1, I_LUI, 0, 0, decode);
      addVec(1, I_LUI, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd2, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_LUI, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 2'd0, 0));
      // AUIPC
      addVec(1, I_AUIPC, 1, 0, fetch_ack);
      addVec(1, I_AUIPC, 0, 0, decode);
      addVec(1, I_AUIPC, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_AUIPC, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 2'd0, 0));
      // R-type ADD
      addVec(1, I_ADD, 1, 0, fetch_ack);
      addVec(1, I_ADD, 0, 0, decode);
      addVec(1, I_ADD, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0));
      addVec(1, I_ADD, 0, 0, o(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 2'd0, 0));
      // SW with immediate ack, then straight back to FETCH
      addVec(1, I_SW, 1, 0, fetch_ack);
      addVec(1, I_SW, 0, 0, decode);
      addVec(1, I_SW, 0, 0, o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 2'd0, 0));
      addVec(1, I_SW, 1, 0, o(3'd3, 1, 1, 1, 0, 0, 2'd0, 2'd0, 1, 0, 0, 2'd0, 0));
      // Illegal opcode -> FAULT
      addVec(1, I_BAD, 1, 0, fetch_ack);
      addVec(1, I_BAD, 0, 0, decode);
      addVec(1, I_BAD, 0, 0, fault_o);

      for (int n = 0; n < vecs.size(); n++) begin
         applyStimulus(vecs[n].rstn, vecs[n].instr, vecs[n].ack, vecs[n].bt);
         checkOutput(vecs[n].exp, $sformatf("vec%0d instr=%08h", n, vecs[n].instr));
      end

      // Fault is sticky regardless of ack / IR activity
      for (int n = 0; n < 20; n++) begin
         applyStimulus(1, I_ADDI, n[0], n[1]);
         checkOutput(fault_o, $sformatf("fault_hold%0d", n));
      end
      applyStimulus(0, I_ADDI, 0, 0);
      checkOutput(zero, "fault_reset");
      applyStimulus(1, I_ADDI, 0, 0);
      checkOutput(fetch_wait, "fault_release_fetch");

      // That FETCH cycle was un-acked cycle 1; 14 more un-acked cycles then FAULT.
      for (int n = 2; n <= 15; n++) begin
         applyStimulus(1, I_ADDI, 0, 0);
         checkOutput(fetch_wait, $sformatf("timeout_wait%0d", n));
      end
      applyStimulus(1, I_ADDI, 0, 0);
      checkOutput(fault_o, "timeout_fault");

      // Ack on the 15th request cycle wins over the timeout
      applyStimulus(0, I_ADDI, 0, 0);
      checkOutput(zero, "timeout2_reset");
      for (int n = 1; n <= 14; n++) begin
         applyStimulus(1, I_ADDI, 0, 0);
         checkOutput(fetch_wait, $sformatf("timeout2_wait%0d", n));
      end
      applyStimulus(1, I_ADDI, 1, 0);
      checkOutput(fetch_ack, "timeout2_ack15");
      applyStimulus(1, I_ADDI, 0, 0);
      checkOutput(decode, "timeout2_decode");

      // Reset during a pending store: nothing must leak out, store never completes
      applyStimulus(0, I_SW, 0, 0);
      checkOutput(zero, "sw_reset0");
      applyStimulus(1, I_SW, 1, 0);
      checkOutput(fetch_ack, "sw_fetch");
      applyStimulus(1, I_SW, 0, 0);
      checkOutput(decode, "sw_decode");
      applyStimulus(1, I_SW, 0, 0);
      checkOutput(o(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 2'd0, 0), "sw_exec");
      applyStimulus(1, I_SW, 0, 0);
      checkOutput(o(3'd3, 1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 2'd0, 0), "sw_mem_wait");
      applyStimulus(0, I_SW, 1, 0);
      checkOutput(zero, "sw_reset_mid_mem");
      applyStimulus(1, I_SW, 0, 0);
      checkOutput(fetch_wait, "sw_after_reset_fetch");
      applyStimulus(1, I_SW, 0, 0);
      checkOutput(fetch_wait, "sw_after_reset_fetch2");

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
